// File: rtl/lsu_mem_if.sv
// Load/store unit: valid/ready memory request channel, lane steering, load extension, fault detection.
// Optional build macro LSU_TIMEOUT_EN adds a REQ/WAIT watchdog that ends stuck accesses with a fault.
module lsu_mem_if #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LB = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state_q, state_d;

  logic            we_q, fault_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [LB-1:0]   lane;
  logic            size_ok, aligned, legal;
  logic            timeout_hit, to_fire;
  logic [XLEN-1:0] shifted, mask, ext, wdata_rep;
  logic            sgn;
  logic [NB-1:0]   strb;

  assign lane = addr_q[LB-1:0];

  always_comb begin
    size_ok = 1'b0;
    aligned = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: size_ok = 1'b1;
      3'b100, 3'b101:         size_ok = ~req_we;
      3'b011:                 size_ok = (XLEN == 64);
      3'b110:                 size_ok = (XLEN == 64) && !req_we;
      default:                size_ok = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~req_addr[0];
      2'd2:    aligned = (req_addr[1:0] == 2'b00);
      default: aligned = (req_addr[2:0] == 3'b000);
    endcase
    legal = size_ok & aligned;
  end

  // Load path: move the addressed lane down to bit 0, then extend from the access size.
  always_comb begin
    shifted = mem_rdata >> {lane, 3'b000};
    case (f3_q[1:0])
      2'd0:    begin mask = XLEN'(8'hFF);         sgn = shifted[7];      end
      2'd1:    begin mask = XLEN'(16'hFFFF);      sgn = shifted[15];     end
      2'd2:    begin mask = XLEN'(32'hFFFF_FFFF); sgn = shifted[31];     end
      default: begin mask = '1;                   sgn = shifted[XLEN-1]; end
    endcase
    ext = (shifted & mask) | ((~f3_q[2] & sgn) ? ~mask : '0);
  end

  always_comb begin
    wdata_rep = '0;
    case (f3_q[1:0])
      2'd0:    begin
        strb = NB'(1);
        for (int unsigned i = 0; i < NB; i++) wdata_rep[8*i +: 8] = wdata_q[7:0];
      end
      2'd1:    begin
        strb = NB'(3);
        for (int unsigned i = 0; i < NB/2; i++) wdata_rep[16*i +: 16] = wdata_q[15:0];
      end
      2'd2:    begin
        strb = NB'(15);
        for (int unsigned i = 0; i < NB/4; i++) wdata_rep[32*i +: 32] = wdata_q[31:0];
      end
      default: begin
        strb      = '1;
        wdata_rep = wdata_q;
      end
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || state_q == IDLE) cnt_q <= '0;
    else if (state_q == REQ || state_q == WAIT) cnt_q <= cnt_q + CW'(1);
  end

  assign timeout_hit = (cnt_q >= CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // A completing handshake wins over a timeout landing in the same cycle.
  assign to_fire = timeout_hit & (((state_q == REQ) & ~mem_ready) | ((state_q == WAIT) & ~mem_rvalid));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = legal ? REQ : RESP;
      REQ:     if (mem_ready) state_d = we_q ? RESP : WAIT;
               else if (to_fire) state_d = RESP;
      WAIT:    if (mem_rvalid || to_fire) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_valid = (state_q == REQ);
    mem_we    = mem_valid & we_q;
    mem_addr  = mem_valid ? {addr_q[XLEN-1:LB], {LB{1'b0}}} : '0;
    mem_wstrb = mem_we ? (strb << lane) : '0;
    mem_wdata = mem_we ? wdata_rep : '0;
    rsp_valid = (state_q == RESP);
    rsp_fault = rsp_valid & fault_q;
    rsp_rdata = rsp_valid ? rdata_q : '0;
    stall     = req_valid & ~rsp_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rdata_q <= '0;
          fault_q <= ~legal;
        end
        WAIT: if (mem_rvalid) rdata_q <= ext;
        default: ;
      endcase
      if (to_fire) fault_q <= 1'b1;
    end
  end
endmodule
